// File: rtl/mem_op_pkg.sv
// Shared types and constants for the memory-operand sequencer.
// State encoding, operation modes and default widths.
package mem_op_pkg;

  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 3;
  localparam int CNT_W_D  = 8;

  localparam logic [1:0] MODE_AND = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_ADD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WR
  } state_t;

endpackage

// File: rtl/mem_op_alu.sv
// Combinational logic-op datapath used in the EXEC step.
// ADD wraps to DATA_W bits; the carry is dropped.
module mem_op_alu
  import mem_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_D
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (mode)
      MODE_AND: y = a & b;
      MODE_OR:  y = a | b;
      MODE_XOR: y = a ^ b;
      MODE_ADD: y = a + b;
    endcase
  end

endmodule

// File: rtl/mem_op_sequencer.sv
// Command-driven sequencer: read A, read B, compute, write back.
// Single RAM master; one-cycle done pulse after each write.
module mem_op_sequencer
  import mem_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [ADDR_W-1:0] cmd_a_addr,
  input  logic [ADDR_W-1:0] cmd_b_addr,
  input  logic [ADDR_W-1:0] cmd_c_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wmode,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  op_count
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_a;
  logic [ADDR_W-1:0]   r_b;
  logic [ADDR_W-1:0]   r_c;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [DATA_W-1:0]   r_result;
  logic                r_done;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   w_alu_y;
  logic                w_acc;

  assign w_acc     = cmd_valid && (r_state == IDLE);
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign mem_wdata = r_result;
  assign result    = r_result;
  assign done      = r_done;
  assign op_count  = r_count;

  mem_op_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .mode(r_mode),
    .a   (r_opa),
    .b   (r_opb),
    .y   (w_alu_y)
  );

  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_wmode = 1'b0;
    unique case (r_state)
      IDLE: if (w_acc) w_next = RD_A;
      RD_A: begin
        mem_addr = r_a;
        w_next   = RD_B;
      end
      RD_B: begin
        mem_addr = r_b;
        w_next   = EXEC;
      end
      EXEC: begin
        mem_addr = r_a;
        w_next   = WR;
      end
      WR: begin
        mem_addr  = r_c;
        mem_wmode = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mode   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == WR);
      if (w_acc) begin
        r_mode <= cmd_mode;
        r_a    <= cmd_a_addr;
        r_b    <= cmd_b_addr;
        r_c    <= cmd_c_addr;
      end
      if (r_state == RD_A) r_opa <= mem_rdata;
      if (r_state == RD_B) r_opb <= mem_rdata;
      if (r_state == EXEC) r_result <= w_alu_y;
      if (r_state == WR) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Randomized bench for mem_op_sequencer against a timeline model.
// Bench owns an 8x32 RAM with combinational read, clocked write.
module tb_mem_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = '0;
  logic [2:0]  cmd_a_addr = '0;
  logic [2:0]  cmd_b_addr = '0;
  logic [2:0]  cmd_c_addr = '0;
  logic [2:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        mem_wmode;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [7:0]  op_count;

  logic        tb_we = 1'b0;
  logic [2:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;
  logic [31:0] mem [8];

  always #5 clk = ~clk;

  mem_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_a_addr(cmd_a_addr),
    .cmd_b_addr(cmd_b_addr),
    .cmd_c_addr(cmd_c_addr),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_wmode (mem_wmode),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .op_count  (op_count)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wmode) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  // Model: cycles since acceptance (0 = idle), plus architectural values.
  int          m_phase = 0;
  logic [2:0]  m_a = '0, m_b = '0, m_c = '0;
  logic [31:0] m_pending = '0;
  logic [31:0] m_result = '0;
  logic [7:0]  m_count = '0;
  logic        m_done = 1'b0;
  logic [31:0] ref_mem [8];

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int wm_cycles = 0;
  int done_hits = 0;
  int last_done_cyc = -1;
  int acc_q [$];
  bit mem_chk = 1'b0;

  function automatic logic [31:0] f(input logic [1:0] md,
                                    input logic [31:0] x,
                                    input logic [31:0] y);
    case (md)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return x + y;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, got, exp, cyc);
  endtask

  task automatic cycle();
    logic       v;
    logic [1:0] md;
    logic [2:0] a, b, c, wa;
    logic       we;
    logic [31:0] wd, ea;
    int p;
    v = cmd_valid; md = cmd_mode;
    a = cmd_a_addr; b = cmd_b_addr; c = cmd_c_addr;
    we = tb_we; wa = tb_waddr; wd = tb_wdata;
    @(posedge clk);
    cyc++;
    p = m_phase;
    m_done = (p == 4);
    if (p == 4) begin
      ref_mem[m_c] = m_result;
      m_count = m_count + 8'd1;
    end
    if (p == 3) m_result = m_pending;
    if (p == 0 && v) begin
      m_a = a; m_b = b; m_c = c;
      m_pending = f(md, ref_mem[a], ref_mem[b]);
      acc_q.push_back(cyc);
    end
    if (we) ref_mem[wa] = wd;
    m_phase = (p == 0) ? (v ? 1 : 0) : ((p == 4) ? 0 : p + 1);
    @(negedge clk);
    if (done) begin
      done_hits++;
      last_done_cyc = cyc;
    end
    if (mem_wmode) wm_cycles++;
    case (m_phase)
      1:       ea = 32'(m_a);
      2:       ea = 32'(m_b);
      3:       ea = 32'(m_a);
      4:       ea = 32'(m_c);
      default: ea = 32'd0;
    endcase
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
    chk("done", 32'(done), 32'(m_done));
    chk("op_count", 32'(op_count), 32'(m_count));
    chk("result", result, m_result);
    chk("mem_wmode", 32'(mem_wmode), 32'(m_phase == 4));
    chk("mem_addr", 32'(mem_addr), ea);
    if (m_phase == 4) chk("mem_wdata", mem_wdata, m_result);
    if (mem_chk)
      for (int i = 0; i < 8; i++) chk("ram", mem[i], ref_mem[i]);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_wmode", 32'(mem_wmode), 32'd0);
    m_phase = 0; m_done = 1'b0; m_result = '0;
    m_count = '0; m_pending = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    cycle();
    tb_we = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!done && k < 12);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic issue(input logic [1:0] md, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] c);
    cmd_mode = md; cmd_a_addr = a; cmd_b_addr = b; cmd_c_addr = c;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    int wm0, k;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    do_reset();
    for (int i = 0; i < 8; i++) wr(3'(i), 32'd0);
    mem_chk = 1'b1;

    wr(3'd1, 32'hF0F0_F0F0);
    wr(3'd2, 32'hFF00_FF00);
    wm0 = wm_cycles;
    acc_q.delete();
    issue(2'b00, 3'd1, 3'd2, 3'd3);
    chk("and_mem3", mem[3], 32'hF000_F000);
    chk("and_result", result, 32'hF000_F000);
    chk("and_count", 32'(op_count), 32'd1);
    chk("and_wm_once", 32'(wm_cycles - wm0), 32'd1);
    chk("and_latency", 32'(last_done_cyc - acc_q[0]), 32'd4);

    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd5, 32'h0000_0001);
    wr(3'd6, 32'hDEAD_BEEF);
    issue(2'b11, 3'd4, 3'd5, 3'd6);
    chk("add_mem6", mem[6], 32'h0000_0000);
    chk("add_result", result, 32'h0000_0000);

    wr(3'd0, 32'h1234_5678);
    wr(3'd7, 32'hFFFF_FFFF);
    issue(2'b10, 3'd0, 3'd7, 3'd0);
    chk("xor_mem0", mem[0], 32'hEDCB_A987);

    for (int i = 0; i < 8; i++) wr(3'(i), $urandom);
    acc_q.delete();
    for (int i = 0; i < 30; i++) begin
      cmd_valid = 1'b1;
      cmd_mode = 2'($urandom);
      cmd_a_addr = 3'($urandom);
      cmd_b_addr = 3'($urandom);
      cmd_c_addr = 3'($urandom);
      cycle();
    end
    cmd_valid = 1'b0;
    k = 0;
    while (busy && k < 10) begin
      cycle();
      k++;
    end
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_accepts", 32'(acc_q.size()), 32'd6);
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_gap", 32'(acc_q[i] - acc_q[i-1]), 32'd5);

    wr(3'd1, 32'hF0F0_F0F0);
    wr(3'd2, 32'hFF00_FF00);
    wr(3'd3, 32'hCAFE_BABE);
    cmd_mode = 2'b01; cmd_a_addr = 3'd1;
    cmd_b_addr = 3'd2; cmd_c_addr = 3'd3;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    do_reset();
    done_hits = 0;
    for (int i = 0; i < 6; i++) cycle();
    chk("rmid_mem3", mem[3], 32'hCAFE_BABE);
    chk("rmid_nodone", 32'(done_hits), 32'd0);
    chk("rmid_count", 32'(op_count), 32'd0);
    issue(2'b01, 3'd1, 3'd2, 3'd3);
    chk("rmid_or_mem3", mem[3], 32'hFFF0_FFF0);
    chk("rmid_or_count", 32'(op_count), 32'd1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(2) == 0) begin
        wr(3'($urandom), $urandom);
      end else begin
        issue(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        k = $urandom_range(2);
        for (int j = 0; j < k; j++) cycle();
      end
    end

    do_reset();
    for (int i = 0; i < 256; i++)
      issue(2'b11, 3'($urandom), 3'($urandom), 3'($urandom));
    chk("wrap_count0", 32'(op_count), 32'd0);
    issue(2'b00, 3'd1, 3'd2, 3'd3);
    chk("wrap_count1", 32'(op_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
